eth_rx_frame: RTL and testbench

Frame-level stage directly downstream of the RMII byte receiver. Consumes the post-SFD byte stream (`rx_data`/`rx_rdy`/`rx_busy`) and computes the Ethernet CRC-32 over it. Checks frame length and destination address, strips the 4-byte FCS, and emits the payload bytes plus one status pulse per frame to the MAC/buffer logic.

---
 rtl/eth_rx_frame.sv | 170 +++++++++++++++++
 tb/tb_eth_rx_frame.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame.sv
// Ethernet receive frame stage: CRC-32 check, length and destination filtering,
// FCS stripping via a 4-byte delay line, and one status strobe per frame.
module eth_rx_frame #(
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        rx_busy,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [2:0]  frame_err,
    output logic        addr_match,
    output logic [10:0] frame_len
);

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

    typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

    state_t      state, state_nxt;
    logic        armed, busy_q, rise, fall;
    logic [31:0] crc, crc_n;
    logic [10:0] cnt, cnt_n, cnt_inc;
    logic [31:0] dl, dl_n;
    logic        am_w, am_n, bc_w, bc_n;
    logic        emit, sof_n, done_n, ok_n, match_n, drop_now;
    logic [2:0]  err_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return MAC_ADDR[47:40];
            3'd1:    return MAC_ADDR[39:32];
            3'd2:    return MAC_ADDR[31:24];
            3'd3:    return MAC_ADDR[23:16];
            3'd4:    return MAC_ADDR[15:8];
            3'd5:    return MAC_ADDR[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // armed blocks a rise on the first clock after reset so an in-progress frame is skipped
    assign rise = armed & rx_busy & ~busy_q;
    assign fall = ~rx_busy & busy_q;

    always_comb begin
        state_nxt = state;
        crc_n     = crc;
        cnt_n     = cnt;
        cnt_inc   = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
        dl_n      = dl;
        am_n      = am_w;
        bc_n      = bc_w;
        emit      = 1'b0;
        sof_n     = 1'b0;
        done_n    = 1'b0;
        err_n     = '0;
        ok_n      = 1'b0;
        match_n   = 1'b0;
        drop_now  = (state == DROP);

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (rise) begin
                    state_nxt = RECV;
                    crc_n     = '1;
                    cnt_n     = '0;
                    dl_n      = '0;
                    am_n      = 1'b1;
                    bc_n      = 1'b1;
                end
            end
            RECV, DROP: begin
                if (rx_rdy) begin
                    cnt_n = cnt_inc;
                    if (!drop_now && cnt_inc > MAX_L) begin
                        drop_now  = 1'b1;
                        state_nxt = DROP;
                    end
                    if (!drop_now) begin
                        crc_n = crc_byte(crc, rx_data);
                        if (cnt < 11'd6) begin
                            if (rx_data != mac_byte(cnt[2:0])) am_n = 1'b0;
                            if (rx_data != 8'hFF)              bc_n = 1'b0;
                        end
                        dl_n = {dl[23:0], rx_data};
                        if (cnt >= 11'd4) begin
                            emit  = 1'b1;
                            sof_n = (cnt == 11'd4);
                        end
                    end
                end
                // a byte arriving with the fall is folded in above before evaluation
                if (fall) begin
                    state_nxt = DONE;
                    done_n    = 1'b1;
                    err_n[0]  = !drop_now && (crc_n != CRC_RES);
                    err_n[1]  = cnt_n < MIN_L;
                    err_n[2]  = cnt_n > MAX_L;
                    match_n   = am_n | (ACCEPT_BCAST & bc_n);
                    ok_n      = (err_n == '0) && match_n;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            busy_q     <= 1'b0;
            crc        <= '1;
            cnt        <= '0;
            dl         <= '0;
            am_w       <= 1'b0;
            bc_w       <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= '0;
            addr_match <= 1'b0;
            frame_len  <= '0;
        end else begin
            armed      <= 1'b1;
            busy_q     <= rx_busy;
            crc        <= crc_n;
            cnt        <= cnt_n;
            dl         <= dl_n;
            am_w       <= am_n;
            bc_w       <= bc_n;
            out_valid  <= emit;
            out_sof    <= sof_n;
            frame_done <= done_n;
            if (emit) out_data <= dl[31:24];
            if (done_n) begin
                frame_ok   <= ok_n;
                frame_err  <= err_n;
                addr_match <= match_n;
                frame_len  <= cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Scoreboard bench for eth_rx_frame: stimulus pushes expected payload/status,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_eth_rx_frame;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        rx_busy = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, frame_done, frame_ok, addr_match;
    logic [2:0]  frame_err;
    logic [10:0] frame_len;

    always #5 clk = ~clk;

    eth_rx_frame #(
        .MAC_ADDR    (48'h02_00_00_00_00_01),
        .ACCEPT_BCAST(1'b1),
        .MIN_LEN     (64),
        .MAX_LEN     (1518)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_busy   (rx_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .addr_match(addr_match),
        .frame_len (frame_len)
    );

    typedef struct packed {logic [7:0] data; logic sof;} byte_t;
    typedef struct packed {logic ok; logic [2:0] err; logic match; logic [10:0] len;} stat_t;

    byte_t      exp_b[$];
    stat_t      exp_s[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    logic [7:0] fr[0:2047];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        byte_t e;
        stat_t s;
        if (out_valid) begin
            if (exp_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out_valid: got byte %0h expected none", out_data);
            end else begin
                e = exp_b.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_sof", 32'(out_sof), 32'(e.sof));
            end
        end
        if (frame_done) begin
            done_cnt++;
            check("payload_count_left", 32'(exp_b.size()), 0);
            if (exp_s.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_frame_done: got len %0d expected none", frame_len);
            end else begin
                s = exp_s.pop_front();
                check("frame_ok", 32'(frame_ok), 32'(s.ok));
                check("frame_err", 32'(frame_err), 32'(s.err));
                check("addr_match", 32'(addr_match), 32'(s.match));
                check("frame_len", 32'(frame_len), 32'(s.len));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] da, input int n, input logic [7:0] seed);
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) fr[i] = da[47-8*i -: 8];
        for (int i = 6; i < 12; i++) fr[i] = 8'hA0 + 8'(i);
        fr[12] = 8'h08;
        fr[13] = 8'h00;
        for (int i = 14; i < n; i++) fr[i] = seed + 8'(i * 7);
        fcs = crc32(n - 4);
        for (int k = 0; k < 4; k++) fr[n-4+k] = fcs[8*k +: 8];
    endtask

    task automatic expect_frame(input int n, input logic ok, input logic [2:0] err,
                                input logic match, input logic [10:0] len);
        int lim;
        lim = (n > 1518) ? 1518 : n;
        for (int i = 0; i < lim - 4; i++) exp_b.push_back({fr[i], (i == 0)});
        exp_s.push_back({ok, err, match, len});
    endtask

    task automatic send(input int n, input bit rdy_on_fall);
        rx_busy = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < n; i++) begin
            rx_data = fr[i];
            rx_rdy  = 1'b1;
            if (rdy_on_fall && i == n - 1) rx_busy = 1'b0;
            tick();
            rx_rdy = 1'b0;
            repeat (3) tick();
        end
        rx_busy = 1'b0;
        repeat (6) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sof"}, 32'(out_sof), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_frame_ok"}, 32'(frame_ok), 0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        check({tag, "_addr_match"}, 32'(addr_match), 0);
        check({tag, "_frame_len"}, 32'(frame_len), 0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // good unicast frame
        build(48'h02_00_00_00_00_01, 64, 8'h11);
        expect_frame(64, 1'b1, 3'b000, 1'b1, 11'd64);
        send(64, 1'b0);

        // same frame, byte 20 corrupted
        build(48'h02_00_00_00_00_01, 64, 8'h11);
        fr[20] = fr[20] ^ 8'h04;
        expect_frame(64, 1'b0, 3'b001, 1'b1, 11'd64);
        send(64, 1'b0);

        // broadcast accepted
        build(48'hFF_FF_FF_FF_FF_FF, 64, 8'h22);
        expect_frame(64, 1'b1, 3'b000, 1'b1, 11'd64);
        send(64, 1'b0);

        // foreign unicast rejected
        build(48'h02_00_00_00_00_02, 64, 8'h33);
        expect_frame(64, 1'b0, 3'b000, 1'b0, 11'd64);
        send(64, 1'b0);

        // runt with valid FCS
        build(48'h02_00_00_00_00_01, 20, 8'h44);
        expect_frame(20, 1'b0, 3'b010, 1'b1, 11'd20);
        send(20, 1'b0);

        // three bytes: no payload, runt and bad CRC, no address match
        fr[0] = 8'hFF;
        fr[1] = 8'hFF;
        fr[2] = 8'h00;
        expect_frame(4, 1'b0, 3'b011, 1'b0, 11'd3);
        send(3, 1'b0);

        // overlength
        build(48'h02_00_00_00_00_01, 1600, 8'h55);
        expect_frame(1600, 1'b0, 3'b100, 1'b1, 11'd1600);
        send(1600, 1'b0);

        // abort mid-frame with reset after byte 30
        build(48'h02_00_00_00_00_01, 64, 8'h66);
        for (int i = 0; i < 26; i++) exp_b.push_back({fr[i], (i == 0)});
        rx_busy = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 30; i++) begin
            rx_data = fr[i];
            rx_rdy  = 1'b1;
            tick();
            rx_rdy = 1'b0;
            repeat (3) tick();
        end
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("abort");
        check("abort_payload_left", 32'(exp_b.size()), 0);
        rst_n = 1'b1;
        // busy still high at release: this frame must be ignored
        for (int i = 30; i < 40; i++) begin
            rx_data = fr[i];
            rx_rdy  = 1'b1;
            tick();
            rx_rdy = 1'b0;
            repeat (3) tick();
        end
        rx_busy = 1'b0;
        repeat (6) tick();

        // good frame with last byte coincident with busy fall
        build(48'h02_00_00_00_00_01, 64, 8'h77);
        expect_frame(64, 1'b1, 3'b000, 1'b1, 11'd64);
        send(64, 1'b1);

        repeat (10) tick();
        check("frame_done_count", 32'(done_cnt), 8);
        check("exp_bytes_left", 32'(exp_b.size()), 0);
        check("exp_status_left", 32'(exp_s.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
